// File: rtl/benes_cfg_loader.sv
// Shadow/active configuration loader for a 32x32 Benes switch fabric.
// Software streams NWORDS words into a shadow buffer; apply_req commits a complete shadow atomically.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting words into shadow, cfg_ready high
// FULL  | shadow complete, waiting for apply_req, incoming words ignored
module benes_cfg_loader #(
  parameter int N_STAGES = 9,
  parameter int N_SW     = 16,
  parameter int WORD_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_W-1:0]          cfg_word,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_clear,
  input  logic                       apply_req,
  output logic [N_STAGES*N_SW-1:0]   switch_set,
  output logic                       shadow_full,
  output logic                       active_valid,
  output logic                       apply_done,
  output logic [2:0]                 load_cnt
);

  localparam int TOTAL = N_STAGES * N_SW;
  localparam int NWORDS = (TOTAL + WORD_W - 1) / WORD_W;
  localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt_nxt;
  logic xfer_ok;
  logic apply_ok;
  logic [TOTAL-1:0] shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      load_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      load_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = load_cnt;
    if (cfg_clear) begin
      state_nxt = LOAD;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer_ok) begin
            cnt_nxt = load_cnt + 3'd1;
            if (load_cnt == LAST_IDX) state_nxt = FULL;
          end
        end
        FULL: begin
          if (apply_req) begin
            state_nxt = LOAD;
            cnt_nxt   = 3'd0;
          end
        end
        default: begin
          state_nxt = LOAD;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Clear outranks both a word transfer and a commit in the same cycle.
  always_comb begin
    cfg_ready   = (state == LOAD);
    shadow_full = (state == FULL);
    xfer_ok     = cfg_ready && cfg_valid && !cfg_clear;
    apply_ok    = (state == FULL) && apply_req && !cfg_clear;
  end

  // One register per word; the last word keeps only the bits that map onto real switches.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    localparam int LO = k * WORD_W;
    localparam int W  = ((LO + WORD_W) <= TOTAL) ? WORD_W : (TOTAL - LO);
    logic [W-1:0] word_q;

    always_ff @(posedge clk) begin
      if (xfer_ok && (load_cnt == 3'(k))) word_q <= cfg_word[W-1:0];
    end

    assign shadow[LO +: W] = word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      switch_set   <= '0;
      active_valid <= 1'b0;
      apply_done   <= 1'b0;
    end else begin
      apply_done <= apply_ok;
      if (apply_ok) begin
        switch_set   <= shadow;
        active_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Randomised and directed stimulus for benes_cfg_loader, checked every cycle against
// a word-queue reference model of the shadow/active configuration behaviour.
module tb_benes_cfg_loader;

  localparam int TOTAL  = 144;
  localparam int WORD_W = 32;
  localparam int NWORDS = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [WORD_W-1:0]  cfg_word;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_clear;
  logic               apply_req;
  logic [TOTAL-1:0]   switch_set;
  logic               shadow_full;
  logic               active_valid;
  logic               apply_done;
  logic [2:0]         load_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [WORD_W-1:0] m_words[$];
  logic              m_full;
  logic [TOTAL-1:0]  m_active;
  logic              m_valid;
  logic              m_done;

  benes_cfg_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_clear    (cfg_clear),
    .apply_req    (apply_req),
    .switch_set   (switch_set),
    .shadow_full  (shadow_full),
    .active_valid (active_valid),
    .apply_done   (apply_done),
    .load_cnt     (load_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TOTAL-1:0] obs, input logic [TOTAL-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [TOTAL-1:0] assemble();
    logic [TOTAL-1:0] v;
    logic [WORD_W-1:0] w;
    v = '0;
    for (int b = 0; b < TOTAL; b++) begin
      w = m_words[b / WORD_W];
      v[b] = w[b % WORD_W];
    end
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_words.delete();
      m_full   = 1'b0;
      m_active = '0;
      m_valid  = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (cfg_clear) begin
        m_words.delete();
        m_full = 1'b0;
      end else if (m_full) begin
        if (apply_req) begin
          m_active = assemble();
          m_valid  = 1'b1;
          m_done   = 1'b1;
          m_words.delete();
          m_full   = 1'b0;
        end
      end else if (cfg_valid) begin
        m_words.push_back(cfg_word);
        if (m_words.size() == NWORDS) m_full = 1'b1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [WORD_W-1:0] w, input logic v,
                     input logic c, input logic a);
    @(negedge clk);
    rst = r; cfg_word = w; cfg_valid = v; cfg_clear = c; apply_req = a;
    @(posedge clk);
    model_step();
    #1;
    check("switch_set", switch_set, m_active);
    check("active_valid", TOTAL'(active_valid), TOTAL'(m_valid));
    check("apply_done", TOTAL'(apply_done), TOTAL'(m_done));
    check("shadow_full", TOTAL'(shadow_full), TOTAL'(m_full));
    check("load_cnt", TOTAL'(load_cnt), TOTAL'(m_full ? NWORDS : m_words.size()));
    check("cfg_ready", TOTAL'(cfg_ready), TOTAL'(!m_full));
  endtask

  task automatic load5(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                       input logic [WORD_W-1:0] w2, input logic [WORD_W-1:0] w3,
                       input logic [WORD_W-1:0] w4);
    cyc(0, w0, 1, 0, 0);
    cyc(0, w1, 1, 0, 0);
    cyc(0, w2, 1, 0, 0);
    cyc(0, w3, 1, 0, 0);
    cyc(0, w4, 1, 0, 0);
  endtask

  initial begin
    logic [TOTAL-1:0] exp_v;
    rst = 1'b1; cfg_word = '0; cfg_valid = 1'b0; cfg_clear = 1'b0; apply_req = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 32'hDEADBEEF, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    check("post_reset_switch", switch_set, '0);

    // all ones; upper 16 bits of word 4 fall off the end
    load5('1, '1, '1, '1, '1);
    cyc(0, 0, 0, 0, 1);
    check("all_ones", switch_set, '1);
    cyc(0, 0, 0, 0, 0);
    check("done_one_cycle", TOTAL'(apply_done), '0);

    // corner bits only
    load5(32'h00000001, 0, 0, 0, 32'hFFFF8000);
    cyc(0, 0, 0, 0, 1);
    exp_v = '0; exp_v[0] = 1'b1; exp_v[TOTAL-1] = 1'b1;
    check("corner_bits", switch_set, exp_v);

    // words offered while full are ignored
    load5(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555);
    cyc(0, 32'hAAAAAAAA, 1, 0, 0);
    cyc(0, 32'hBBBBBBBB, 1, 0, 0);
    cyc(0, 32'hCCCCCCCC, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("full_hold_word0", TOTAL'(switch_set[31:0]), TOTAL'(32'h11111111));

    // clear with a transfer, then apply with partial shadow
    cyc(0, 32'h01010101, 1, 0, 0);
    cyc(0, 32'h02020202, 1, 0, 0);
    cyc(0, 32'h03030303, 1, 1, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    load5(32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h0000A5A5);
    cyc(0, 0, 0, 1, 1);
    load5(32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h0000A5A5);
    cyc(0, 0, 0, 0, 1);

    // reset mid-load after a commit
    cyc(0, 32'hFACEFACE, 1, 0, 0);
    cyc(0, 32'hFACEFACE, 1, 0, 0);
    cyc(0, 32'hFACEFACE, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_clears_active", switch_set, '0);

    for (int i = 0; i < 3000; i++) begin
      logic [WORD_W-1:0] w;
      w = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      cyc($urandom_range(0, 299) == 0, w, $urandom_range(0, 1) == 1,
          $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
